// File: rtl/lock_controller_if.sv
// Signal bundle between the password entry register / system logic and the lock controller.
interface lock_controller_if;
    logic        identity;
    logic        edit_req;
    logic        digit_valid;
    logic        ok_pulse;
    logic        admin_clear;
    logic [15:0] entry;
    logic [1:0]  state;
    logic [3:0]  leds;
    logic        unlock;
    logic        alarm;
    logic [1:0]  err_count;
    logic [15:0] stored_pswd;
    logic        entry_clear;
    logic        set_done;

    modport master (
        output identity, edit_req, digit_valid, ok_pulse, admin_clear, entry,
        input  state, leds, unlock, alarm, err_count, stored_pswd, entry_clear, set_done
    );

    modport slave (
        input  identity, edit_req, digit_valid, ok_pulse, admin_clear, entry,
        output state, leds, unlock, alarm, err_count, stored_pswd, entry_clear, set_done
    );
endinterface

// File: rtl/lock_controller.sv
// Lock state machine: password check, admin password set, wrong-attempt alarm and LED status.
// All outputs registered: an input pulse at edge N is reflected at edge N+1; no backpressure.
module lock_controller #(
    parameter int          CLK_PER_MS        = 50000,
    parameter int          EDIT_TIMEOUT_MS   = 10000,
    parameter int          UNLOCK_TIMEOUT_MS = 20000,
    parameter int          BLINK_MS          = 500,
    parameter int          MAX_ERRORS        = 3,
    parameter logic [15:0] DEFAULT_PSWD      = 16'h1234
) (
    input  logic               clk,
    input  logic               rst,
    lock_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_EDIT   = 2'b01,
        ST_UNLOCK = 2'b10,
        ST_ALARM  = 2'b11
    } state_t;

    localparam int MAX_EU = (EDIT_TIMEOUT_MS > UNLOCK_TIMEOUT_MS) ? EDIT_TIMEOUT_MS : UNLOCK_TIMEOUT_MS;
    localparam int MAX_MS = (MAX_EU > BLINK_MS) ? MAX_EU : BLINK_MS;
    localparam int MSW    = $clog2(MAX_MS + 1);
    localparam int PW     = $clog2(CLK_PER_MS + 1);

    state_t          st, st_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [MSW-1:0]  ms_cnt, ms_nxt;
    logic [1:0]      err, err_nxt, err_inc;
    logic [15:0]     pswd, pswd_nxt;
    logic [3:0]      leds, leds_nxt;
    logic            clr_q, done_q, unlock_q, alarm_q;
    logic            clr_nxt, done_nxt, restart;
    logic            ms_tick, edit_to, unl_to, blink_to;
    logic            entry_bcd, entry_match;

    assign ms_tick  = (presc == PW'(CLK_PER_MS - 1));
    assign edit_to  = ms_tick && (ms_cnt == MSW'(EDIT_TIMEOUT_MS - 1));
    assign unl_to   = ms_tick && (ms_cnt == MSW'(UNLOCK_TIMEOUT_MS - 1));
    assign blink_to = ms_tick && (ms_cnt == MSW'(BLINK_MS - 1));

    assign entry_bcd   = (bus.entry[15:12] <= 4'd9) && (bus.entry[11:8] <= 4'd9) &&
                         (bus.entry[7:4]   <= 4'd9) && (bus.entry[3:0]  <= 4'd9);
    assign entry_match = (bus.entry == pswd);
    assign err_inc     = (err == 2'(MAX_ERRORS)) ? err : err + 2'd1;

    always_comb begin
        st_nxt    = st;
        err_nxt   = err;
        pswd_nxt  = pswd;
        leds_nxt  = leds;
        clr_nxt   = 1'b0;
        done_nxt  = 1'b0;
        restart   = 1'b0;
        presc_nxt = presc;
        ms_nxt    = ms_cnt;

        case (st)
            ST_WAIT: begin
                if (bus.edit_req)
                    st_nxt = ST_EDIT;
            end
            ST_EDIT: begin
                if (bus.ok_pulse) begin
                    if (bus.identity) begin
                        clr_nxt = 1'b1;
                        if (entry_match && entry_bcd) begin
                            st_nxt  = ST_UNLOCK;
                            err_nxt = 2'd0;
                        end else begin
                            err_nxt = err_inc;
                            st_nxt  = (err_inc == 2'(MAX_ERRORS)) ? ST_ALARM : ST_WAIT;
                        end
                    end else if (entry_bcd) begin
                        pswd_nxt = bus.entry;
                        err_nxt  = 2'd0;
                        done_nxt = 1'b1;
                        clr_nxt  = 1'b1;
                        st_nxt   = ST_WAIT;
                    end else begin
                        restart = 1'b1;
                    end
                end else if (edit_to) begin
                    st_nxt  = ST_WAIT;
                    clr_nxt = 1'b1;
                end else if (bus.digit_valid) begin
                    restart = 1'b1;
                end
            end
            ST_UNLOCK: begin
                if (bus.ok_pulse || unl_to) begin
                    st_nxt  = ST_WAIT;
                    clr_nxt = 1'b1;
                end
            end
            ST_ALARM: begin
                if (bus.admin_clear) begin
                    st_nxt  = ST_WAIT;
                    err_nxt = 2'd0;
                    clr_nxt = 1'b1;
                end else if (blink_to) begin
                    // ms counter doubles as the blink half-period timer while alarming
                    restart  = 1'b1;
                    leds_nxt = ~leds;
                end
            end
            default: ;
        endcase

        case (st_nxt)
            ST_WAIT:   leds_nxt = 4'b0001;
            ST_EDIT:   leds_nxt = 4'b0011;
            ST_UNLOCK: leds_nxt = 4'b1111;
            ST_ALARM:  if (st != ST_ALARM) leds_nxt = 4'b1111;
            default: ;
        endcase

        if (restart || (st_nxt != st)) begin
            presc_nxt = '0;
            ms_nxt    = '0;
        end else if (ms_tick) begin
            presc_nxt = '0;
            ms_nxt    = ms_cnt + MSW'(1);
        end else begin
            presc_nxt = presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_WAIT;
            err      <= 2'd0;
            pswd     <= DEFAULT_PSWD;
            leds     <= 4'b0001;
            presc    <= '0;
            ms_cnt   <= '0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            st       <= st_nxt;
            err      <= err_nxt;
            pswd     <= pswd_nxt;
            leds     <= leds_nxt;
            presc    <= presc_nxt;
            ms_cnt   <= ms_nxt;
            clr_q    <= clr_nxt;
            done_q   <= done_nxt;
            unlock_q <= (st_nxt == ST_UNLOCK);
            alarm_q  <= (st_nxt == ST_ALARM);
        end
    end

    assign bus.state       = st;
    assign bus.leds        = leds;
    assign bus.unlock      = unlock_q;
    assign bus.alarm       = alarm_q;
    assign bus.err_count   = err;
    assign bus.stored_pswd = pswd;
    assign bus.entry_clear = clr_q;
    assign bus.set_done    = done_q;
endmodule
